// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : cond_unit
// Description : ARM-style conditional-execution unit. Holds NUM_BANKS NZCV
//               flag registers, evaluates the instruction condition against
//               the selected bank, gates RegWrite/MemWrite/PCSrc, updates
//               flags for executed flag-setting instructions, and sequences
//               IT-block predication for up to MAX_IT_LEN instructions.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   valid_i           : instruction present this cycle
//   stall_i           : hold all state (outputs still track inputs)
//   flush_i           : kill current instruction, abandon any IT block
//   cond_i            : instruction condition field
//   alu_flags_i       : ALU flags packed {C,N,V,Z}
//   flag_write_i      : [1] writes N,Z   [0] writes C,V
//   bank_sel_i        : flag bank for evaluate and update
//   reg_write_i, mem_write_i, pc_src_i : ungated control
//   it_start_i, it_cond_i, it_len_i, it_then_i : IT instruction fields
//   cond_ex_o         : instruction executes
//   reg_write_o, mem_write_o, pc_src_o : gated control
//   undef_o           : effective condition is 1111
//   it_active_o       : IT block in progress
//   it_err_o          : one-cycle pulse after an IT inside an IT block
//   flags_o           : selected bank flags {C,N,V,Z}
// ============================================================================
module cond_unit #(
  parameter  int NUM_BANKS  = 2,
  parameter  int MAX_IT_LEN = 4,
  parameter  int REG_OUT    = 0,
  localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int LEN_W      = $clog2(MAX_IT_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [3:0]            cond_i,
  input  logic [3:0]            alu_flags_i,
  input  logic [1:0]            flag_write_i,
  input  logic [BANK_W-1:0]     bank_sel_i,
  input  logic                  reg_write_i,
  input  logic                  mem_write_i,
  input  logic                  pc_src_i,
  input  logic                  it_start_i,
  input  logic [3:0]            it_cond_i,
  input  logic [LEN_W-1:0]      it_len_i,
  input  logic [MAX_IT_LEN-1:0] it_then_i,
  output logic                  cond_ex_o,
  output logic                  reg_write_o,
  output logic                  mem_write_o,
  output logic                  pc_src_o,
  output logic                  undef_o,
  output logic                  it_active_o,
  output logic                  it_err_o,
  output logic [3:0]            flags_o
);

  // Flag bit positions inside the packed {C,N,V,Z} word.
  localparam int FC = 3;
  localparam int FN = 2;
  localparam int FV = 1;
  localparam int FZ = 0;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_IT_LEN);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    IT_ACTIVE = 1'b1
  } it_state_t;

  // --------------------------------------------------------------------------
  // Condition evaluation. Odd encodings are the inverse of the even one below
  // them; 1110 (AL) is always true. 1111 is handled separately as undefined.
  // --------------------------------------------------------------------------
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic base;
    logic ge;
    ge = (f[FN] == f[FV]);
    case (c[3:1])
      3'b000:  base = f[FZ];
      3'b001:  base = f[FC];
      3'b010:  base = f[FN];
      3'b011:  base = f[FV];
      3'b100:  base = f[FC] & ~f[FZ];
      3'b101:  base = ge;
      3'b110:  base = ~f[FZ] & ge;
      default: base = 1'b1;
    endcase
    if (c[3:1] == 3'b111) begin
      cond_pass = 1'b1;
    end else begin
      cond_pass = base ^ c[0];
    end
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [3:0]            bank_flags [NUM_BANKS];
  it_state_t             state_q;
  it_state_t             state_d;
  logic [LEN_W-1:0]      slot_q;
  logic [LEN_W-1:0]      slot_d;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      len_d;
  logic [3:0]            base_q;
  logic [3:0]            base_d;
  logic [MAX_IT_LEN-1:0] then_q;
  logic [MAX_IT_LEN-1:0] then_d;
  logic                  it_err_q;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic                  active;
  logic                  live;
  logic                  accept;
  logic                  is_it_instr;
  logic                  then_bit;
  logic [3:0]            eff_cond;
  logic                  eff_undef;
  logic [3:0]            cur_flags;
  logic                  cond_ex_c;
  logic                  undef_c;
  logic                  reg_write_c;
  logic                  mem_write_c;
  logic                  pc_src_c;
  logic                  flag_we;
  logic [LEN_W-1:0]      len_clamped;
  logic                  last_slot;

  assign active      = (state_q == IT_ACTIVE);
  assign live        = valid_i & ~flush_i;
  assign accept      = live & ~stall_i;
  // An IT inside an active block is treated as an ordinary slot instruction.
  assign is_it_instr = ~active & it_start_i;

  // Read-side bank mux; an out-of-range select reads zero.
  always_comb begin
    cur_flags = 4'b0000;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_sel_i == BANK_W'(b)) begin
        cur_flags = bank_flags[b];
      end
    end
  end

  // Then-mask bit for the current slot, selected by compare to avoid an
  // index wider than the mask.
  always_comb begin
    then_bit = 1'b0;
    for (int k = 0; k < MAX_IT_LEN; k++) begin
      if (slot_q == LEN_W'(k)) begin
        then_bit = then_q[k];
      end
    end
  end

  always_comb begin
    eff_cond = cond_i;
    if (active) begin
      if ((slot_q == '0) || then_bit) begin
        eff_cond = base_q;
      end else begin
        eff_cond = {base_q[3:1], ~base_q[0]};
      end
    end
  end

  // The IT instruction itself always executes regardless of cond_i.
  assign eff_undef   = (eff_cond == 4'b1111) & ~is_it_instr;
  assign cond_ex_c   = live & (is_it_instr | (~eff_undef & cond_pass(eff_cond, cur_flags)));
  assign undef_c     = live & eff_undef;
  assign reg_write_c = reg_write_i & cond_ex_c;
  assign mem_write_c = mem_write_i & cond_ex_c;
  assign pc_src_c    = pc_src_i & cond_ex_c;
  assign flag_we     = accept & cond_ex_c;

  assign len_clamped = (it_len_i == '0)     ? LEN_ONE :
                       (it_len_i > LEN_MAX) ? LEN_MAX : it_len_i;
  assign last_slot   = (slot_q == LEN_W'(len_q - LEN_ONE));

  // --------------------------------------------------------------------------
  // Flag banks: only the selected bank is written, and only for an accepted,
  // executed instruction. Evaluation above sees the pre-update value.
  // --------------------------------------------------------------------------
  for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
    always_ff @(posedge clk) begin
      if (reset) begin
        bank_flags[gb] <= 4'b0000;
      end else if (flag_we && (bank_sel_i == BANK_W'(gb))) begin
        if (flag_write_i[1]) begin
          bank_flags[gb][FN] <= alu_flags_i[FN];
          bank_flags[gb][FZ] <= alu_flags_i[FZ];
        end
        if (flag_write_i[0]) begin
          bank_flags[gb][FC] <= alu_flags_i[FC];
          bank_flags[gb][FV] <= alu_flags_i[FV];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // IT sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      len_q    <= LEN_ONE;
      base_q   <= 4'b0000;
      then_q   <= '0;
      it_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      len_q    <= len_d;
      base_q   <= base_d;
      then_q   <= then_d;
      it_err_q <= accept & active & it_start_i;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    len_d   = len_q;
    base_d  = base_q;
    then_d  = then_q;
    // Flush wins over stall and over a simultaneous IT start.
    if (flush_i) begin
      state_d = IDLE;
      slot_d  = '0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (it_start_i) begin
            state_d = IT_ACTIVE;
            slot_d  = '0;
            len_d   = len_clamped;
            base_d  = it_cond_i;
            then_d  = it_then_i;
          end
        end
        IT_ACTIVE: begin
          if (last_slot) begin
            state_d = IDLE;
            slot_d  = '0;
          end else begin
            slot_d  = slot_q + LEN_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          slot_d  = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign it_active_o = active;
  assign it_err_o    = it_err_q;
  assign flags_o     = cur_flags;

  if (REG_OUT != 0) begin : g_reg_out
    always_ff @(posedge clk) begin
      if (reset || flush_i) begin
        cond_ex_o   <= 1'b0;
        undef_o     <= 1'b0;
        reg_write_o <= 1'b0;
        mem_write_o <= 1'b0;
        pc_src_o    <= 1'b0;
      end else if (!stall_i) begin
        cond_ex_o   <= cond_ex_c;
        undef_o     <= undef_c;
        reg_write_o <= reg_write_c;
        mem_write_o <= mem_write_c;
        pc_src_o    <= pc_src_c;
      end
    end
  end else begin : g_comb_out
    assign cond_ex_o   = cond_ex_c;
    assign undef_o     = undef_c;
    assign reg_write_o = reg_write_c;
    assign mem_write_o = mem_write_c;
    assign pc_src_o    = pc_src_c;
  end

endmodule
`default_nettype wire

// File: tb/tb_cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cond_unit
// Description : Scoreboard bench for cond_unit. Each directed step drives one
//               cycle of inputs and queues the hand-computed outputs for that
//               cycle; a monitor pops and compares on the falling edge.
//               Observed word: {cond_ex, rw, mw, pc, undef, it_active,
//               it_err, flags[3:0]} with flags packed {C,N,V,Z}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_unit;

  localparam int NUM_BANKS  = 2;
  localparam int MAX_IT_LEN = 4;
  localparam int BANK_W     = 1;
  localparam int LEN_W      = 3;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  valid_i = 1'b0;
  logic                  stall_i = 1'b0;
  logic                  flush_i = 1'b0;
  logic [3:0]            cond_i = 4'h0;
  logic [3:0]            alu_flags_i = 4'h0;
  logic [1:0]            flag_write_i = 2'b00;
  logic [BANK_W-1:0]     bank_sel_i = '0;
  logic                  reg_write_i = 1'b0;
  logic                  mem_write_i = 1'b0;
  logic                  pc_src_i = 1'b0;
  logic                  it_start_i = 1'b0;
  logic [3:0]            it_cond_i = 4'h0;
  logic [LEN_W-1:0]      it_len_i = '0;
  logic [MAX_IT_LEN-1:0] it_then_i = '0;
  logic                  cond_ex_o;
  logic                  reg_write_o;
  logic                  mem_write_o;
  logic                  pc_src_o;
  logic                  undef_o;
  logic                  it_active_o;
  logic                  it_err_o;
  logic [3:0]            flags_o;

  cond_unit #(
    .NUM_BANKS (NUM_BANKS),
    .MAX_IT_LEN(MAX_IT_LEN),
    .REG_OUT   (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_i     (valid_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .cond_i      (cond_i),
    .alu_flags_i (alu_flags_i),
    .flag_write_i(flag_write_i),
    .bank_sel_i  (bank_sel_i),
    .reg_write_i (reg_write_i),
    .mem_write_i (mem_write_i),
    .pc_src_i    (pc_src_i),
    .it_start_i  (it_start_i),
    .it_cond_i   (it_cond_i),
    .it_len_i    (it_len_i),
    .it_then_i   (it_then_i),
    .cond_ex_o   (cond_ex_o),
    .reg_write_o (reg_write_o),
    .mem_write_o (mem_write_o),
    .pc_src_o    (pc_src_o),
    .undef_o     (undef_o),
    .it_active_o (it_active_o),
    .it_err_o    (it_err_o),
    .flags_o     (flags_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [10:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Monitor: one observation per queued cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_entry_t   e;
      logic [10:0] act;
      e   = sb_q.pop_front();
      act = {cond_ex_o, reg_write_o, mem_write_o, pc_src_o, undef_o,
             it_active_o, it_err_o, flags_o};
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b, expected %b (cex,rw,mw,pc,und,act,err,CNVZ)",
                 e.name, act, e.exp);
      end
    end
  end

  // One cycle of stimulus plus its expected outputs.
  // ctl = {reg_write, mem_write, pc_src}; it = {start, cond, len, then}.
  task automatic step(input string name, input logic v, input logic st,
                      input logic fl, input logic [3:0] c, input logic [3:0] alu,
                      input logic [1:0] fw, input logic bk, input logic [2:0] ctl,
                      input logic its, input logic [3:0] itc,
                      input logic [LEN_W-1:0] itl, input logic [3:0] itt,
                      input logic e_cex, input logic [2:0] e_ctl,
                      input logic e_und, input logic e_act, input logic e_err,
                      input logic [3:0] e_flags);
    sb_entry_t e;
    @(posedge clk);
    #1;
    valid_i      = v;
    stall_i      = st;
    flush_i      = fl;
    cond_i       = c;
    alu_flags_i  = alu;
    flag_write_i = fw;
    bank_sel_i   = bk;
    {reg_write_i, mem_write_i, pc_src_i} = ctl;
    it_start_i   = its;
    it_cond_i    = itc;
    it_len_i     = itl;
    it_then_i    = itt;
    e.name = name;
    e.exp  = {e_cex, e_ctl, e_und, e_act, e_err, e_flags};
    sb_q.push_back(e);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    //                           v  st fl cond  alu    fw    bk ctl     its itc  itl  itt       cex ctl    und act err flags
    step("reset_state",          0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 3'b000, 0, 4'h0, 3'd0, 4'b0000, 0, 3'b000, 0, 0, 0, 4'b0000);
    step("adds_z_al",            1, 0, 0, 4'hE, 4'h1, 2'b11, 0, 3'b100, 0, 4'h0, 3'd0, 4'b0000, 1, 3'b100, 0, 0, 0, 4'b0000);
    step("eq_taken",             1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 3'b100, 0, 4'h0, 3'd0, 4'b0000, 1, 3'b100, 0, 0, 0, 4'b0001);
    step("ne_not_taken",         1, 0, 0, 4'h1, 4'h0, 2'b00, 0, 3'b111, 0, 4'h0, 3'd0, 4'b0000, 0, 3'b000, 0, 0, 0, 4'b0001);
    step("set_bank1_c",          1, 0, 0, 4'hE, 4'h8, 2'b01, 1, 3'b000, 0, 4'h0, 3'd0, 4'b0000, 1, 3'b000, 0, 0, 0, 4'b0000);
    step("bank0_cs",             1, 0, 0, 4'h2, 4'h0, 2'b00, 0, 3'b100, 0, 4'h0, 3'd0, 4'b0000, 0, 3'b000, 0, 0, 0, 4'b0001);
    step("bank1_cs",             1, 0, 0, 4'h2, 4'h0, 2'b00, 1, 3'b100, 0, 4'h0, 3'd0, 4'b0000, 1, 3'b100, 0, 0, 0, 4'b1000);
    // IT EQ, len 3, then slots {1,0,1}; Z=1 in bank0
    step("it_eq_instr",          1, 0, 0, 4'hF, 4'h0, 2'b00, 0, 3'b000, 1, 4'h0, 3'd3, 4'b0101, 1, 3'b000, 0, 0, 0, 4'b0001);
    step("it_eq_slot0",          1, 0, 0, 4'h1, 4'h0, 2'b00, 0, 3'b100, 0, 4'h0, 3'd0, 4'b0000, 1, 3'b100, 0, 1, 0, 4'b0001);
    step("it_eq_slot1_stall",    1, 1, 0, 4'h0, 4'h0, 2'b00, 0, 3'b100, 0, 4'h0, 3'd0, 4'b0000, 0, 3'b000, 0, 1, 0, 4'b0001);
    step("it_eq_slot1",          1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 3'b100, 0, 4'h0, 3'd0, 4'b0000, 0, 3'b000, 0, 1, 0, 4'b0001);
    step("it_eq_slot2",          1, 0, 0, 4'h1, 4'h0, 2'b00, 0, 3'b100, 0, 4'h0, 3'd0, 4'b0000, 1, 3'b100, 0, 1, 0, 4'b0001);
    step("it_eq_done",           0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 3'b000, 0, 4'h0, 3'd0, 4'b0000, 0, 3'b000, 0, 0, 0, 4'b0001);
    // Undefined condition: no execute, no flag write
    step("undef_cond",           1, 0, 0, 4'hF, 4'hF, 2'b11, 0, 3'b111, 0, 4'h0, 3'd0, 4'b0000, 0, 3'b000, 1, 0, 0, 4'b0001);
    step("undef_no_write",       0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 3'b000, 0, 4'h0, 3'd0, 4'b0000, 0, 3'b000, 0, 0, 0, 4'b0001);
    // IT AL, len 2, slot1 inverted -> 1111
    step("it_al_instr",          1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 3'b000, 1, 4'hE, 3'd2, 4'b0001, 1, 3'b000, 0, 0, 0, 4'b0001);
    step("it_al_slot0",          1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 3'b100, 0, 4'h0, 3'd0, 4'b0000, 1, 3'b100, 0, 1, 0, 4'b0001);
    step("it_al_slot1_undef",    1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 3'b100, 0, 4'h0, 3'd0, 4'b0000, 0, 3'b000, 1, 1, 0, 4'b0001);
    // Nested IT rejected; length stays 2
    step("it_b_instr",           1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 3'b000, 1, 4'hE, 3'd2, 4'b0011, 1, 3'b000, 0, 0, 0, 4'b0001);
    step("it_b_nested_start",    1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 3'b000, 1, 4'h0, 3'd4, 4'b0000, 1, 3'b000, 0, 1, 0, 4'b0001);
    step("it_b_slot1_err",       1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 3'b100, 0, 4'h0, 3'd0, 4'b0000, 1, 3'b100, 0, 1, 1, 4'b0001);
    step("it_b_done",            0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 3'b000, 0, 4'h0, 3'd0, 4'b0000, 0, 3'b000, 0, 0, 0, 4'b0001);
    // Flush at slot 1
    step("it_c_instr",           1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 3'b000, 1, 4'h0, 3'd3, 4'b0111, 1, 3'b000, 0, 0, 0, 4'b0001);
    step("it_c_slot0",           1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 3'b100, 0, 4'h0, 3'd0, 4'b0000, 1, 3'b100, 0, 1, 0, 4'b0001);
    step("it_c_slot1_flush",     1, 0, 1, 4'hE, 4'h0, 2'b11, 0, 3'b111, 0, 4'h0, 3'd0, 4'b0000, 0, 3'b000, 0, 1, 0, 4'b0001);
    step("post_flush",           0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 3'b000, 0, 4'h0, 3'd0, 4'b0000, 0, 3'b000, 0, 0, 0, 4'b0001);
    // Same-cycle write and evaluate
    step("clear_z",              1, 0, 0, 4'hE, 4'h0, 2'b10, 0, 3'b000, 0, 4'h0, 3'd0, 4'b0000, 1, 3'b000, 0, 0, 0, 4'b0001);
    step("adds_ne_old_z",        1, 0, 0, 4'h1, 4'h1, 2'b10, 0, 3'b100, 0, 4'h0, 3'd0, 4'b0000, 1, 3'b100, 0, 0, 0, 4'b0000);
    step("eq_new_z",             1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 3'b100, 0, 4'h0, 3'd0, 4'b0000, 1, 3'b100, 0, 0, 0, 4'b0001);
    // Length 0 behaves as length 1
    step("it_len0_instr",        1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 3'b000, 1, 4'h0, 3'd0, 4'b0000, 1, 3'b000, 0, 0, 0, 4'b0001);
    step("it_len0_slot0",        1, 0, 0, 4'h1, 4'h0, 2'b00, 0, 3'b010, 0, 4'h0, 3'd0, 4'b0000, 1, 3'b010, 0, 1, 0, 4'b0001);
    step("it_len0_done",         0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 3'b000, 0, 4'h0, 3'd0, 4'b0000, 0, 3'b000, 0, 0, 0, 4'b0001);
    // Signed / unsigned compares with flags 0001 (Z=1, N=V=0, C=0)
    step("ge_taken",             1, 0, 0, 4'hA, 4'h0, 2'b00, 0, 3'b001, 0, 4'h0, 3'd0, 4'b0000, 1, 3'b001, 0, 0, 0, 4'b0001);
    step("gt_not_taken",         1, 0, 0, 4'hC, 4'h0, 2'b00, 0, 3'b001, 0, 4'h0, 3'd0, 4'b0000, 0, 3'b000, 0, 0, 0, 4'b0001);
    step("hi_not_taken",         1, 0, 0, 4'h8, 4'h0, 2'b00, 0, 3'b010, 0, 4'h0, 3'd0, 4'b0000, 0, 3'b000, 0, 0, 0, 4'b0001);
    step("ls_taken",             1, 0, 0, 4'h9, 4'h0, 2'b00, 0, 3'b010, 0, 4'h0, 3'd0, 4'b0000, 1, 3'b010, 0, 0, 0, 4'b0001);
    // Flush overrides a simultaneous IT start
    step("flush_with_it_start",  1, 0, 1, 4'hE, 4'h0, 2'b00, 0, 3'b111, 1, 4'hE, 3'd2, 4'b0011, 0, 3'b000, 0, 0, 0, 4'b0001);
    step("after_flush_it_start", 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 3'b000, 0, 4'h0, 3'd0, 4'b0000, 0, 3'b000, 0, 0, 0, 4'b0001);

    // Drain the scoreboard with a bounded wait.
    begin
      int budget;
      budget = 20;
      while (sb_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (sb_q.size() > 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
